// File: rtl/ddr2_aref_pkg.sv
// Shared DDR2 command encodings, bus widths and timing defaults.
// The init sequencer imports the same package so encodings live in one place.
package ddr2_aref_pkg;

    localparam int BA_BITS   = 2;
    localparam int ADDR_BITS = 13;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LM   = 4'b0000;

    // A10 high selects all banks on PRECHARGE
    localparam logic [ADDR_BITS-1:0] PRE_ALL_ADDR = 13'h0400;

    // Clock period and JEDEC timings in picoseconds
    localparam int TCK_PS   = 2500;
    localparam int TREFI_PS = 7_800_000;
    localparam int TRP_PS   = 12_500;
    localparam int TRFC_PS  = 127_500;

    // Minimum spacings round up; the refresh interval rounds down so refreshes are never late
    function automatic int ps_to_ck_ceil(input int ps);
        return (ps + TCK_PS - 1) / TCK_PS;
    endfunction

    localparam int TREFI_CK_DFLT = TREFI_PS / TCK_PS;
    localparam int TRP_CK_DFLT   = ps_to_ck_ceil(TRP_PS);
    localparam int TRFC_CK_DFLT  = ps_to_ck_ceil(TRFC_PS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WRP,
        ST_REF,
        ST_WRFC
    } aref_state_e;

endpackage

// File: rtl/ddr2_aref.sv
// DDR2 auto-refresh scheduler: counts tREFI once init is done, tracks postponed
// refreshes, and on arbiter grant issues PRECHARGE-ALL followed by AUTO REFRESH.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no sequence; aref_req raised when refreshes are pending
// PRE   | PRECHARGE-ALL on the bus (A10=1)
// WRP   | NOPs for the remaining tRP cycles
// REF   | AUTO REFRESH on the bus
// WRFC  | NOPs for the remaining tRFC cycles; last cycle pulses aref_end
module ddr2_aref
    import ddr2_aref_pkg::*;
#(
    parameter int TREFI_CK = TREFI_CK_DFLT,
    parameter int TRP_CK   = TRP_CK_DFLT,
    parameter int TRFC_CK  = TRFC_CK_DFLT,
    parameter int MAX_PEND = 8
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 init_end,
    input  logic                 aref_en,
    output logic                 aref_req,
    output logic                 aref_busy,
    output logic [3:0]           aref_cmd,
    output logic [BA_BITS-1:0]   aref_ba,
    output logic [ADDR_BITS-1:0] aref_addr,
    output logic                 aref_end,
    output logic                 aref_overflow
);

    localparam int REFI_W = (TREFI_CK > 1) ? $clog2(TREFI_CK) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int PH_MAX = (TRP_CK > TRFC_CK) ? TRP_CK : TRFC_CK;
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(TREFI_CK - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
    // Wait states already account for the PRE/REF command cycle, hence the -2
    localparam logic [PH_W-1:0]   WRP_LOAD  = PH_W'(TRP_CK - 2);
    localparam logic [PH_W-1:0]   WRFC_LOAD = PH_W'(TRFC_CK - 2);

    aref_state_e          state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [REFI_W-1:0]    cnt_refi_q, cnt_refi_d;
    logic [PEND_W-1:0]    pend_q, pend_d;
    logic                 ovf_q, ovf_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 end_q, end_d;
    logic                 tick;
    logic                 seq_done;

    assign tick     = init_end && (cnt_refi_q == REFI_LAST);
    assign seq_done = (state_q == ST_WRFC) && (phase_q == '0);

    // Interval counter: idle until init completes, then free-runs 0..TREFI_CK-1
    always_comb begin
        cnt_refi_d = cnt_refi_q + 1'b1;
        if (!init_end || tick) begin
            cnt_refi_d = '0;
        end
    end

    // Pending-refresh bookkeeping; a tick and a completion in the same cycle cancel
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !seq_done) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (seq_done && !tick) begin
            pend_d = pend_q - 1'b1;
        end
    end

    assign aref_req = (state_q == ST_IDLE) && init_end && (pend_q != '0);

    // Sequence FSM; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        busy_d  = 1'b1;
        end_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: if (aref_req && aref_en) state_d = ST_PRE;
            ST_PRE: begin
                state_d = ST_WRP;
                phase_d = WRP_LOAD;
            end
            ST_WRP: begin
                if (phase_q == '0) state_d = ST_REF;
                else               phase_d = phase_q - 1'b1;
            end
            ST_REF: begin
                state_d = ST_WRFC;
                phase_d = WRFC_LOAD;
            end
            ST_WRFC: begin
                if (phase_q == '0) state_d = ST_IDLE;
                else               phase_d = phase_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_IDLE: busy_d = 1'b0;
            ST_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = PRE_ALL_ADDR;
            end
            ST_REF:  cmd_d = CMD_AREF;
            ST_WRFC: end_d = (phase_d == '0);
            default: ;
        endcase
    end

    // All state and output registers; reset aborts any sequence in flight
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            cnt_refi_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_refi_q <= cnt_refi_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
        end
    end

    assign aref_busy     = busy_q;
    assign aref_cmd      = cmd_q;
    assign aref_ba       = '0;
    assign aref_addr     = addr_q;
    assign aref_end      = end_q;
    assign aref_overflow = ovf_q;

endmodule

// File: tb/tb_ddr2_aref.sv
// Scoreboard bench for ddr2_aref: a cycle-level reference model predicts the
// command stream and status flags; a negedge monitor compares against the DUT.
module tb_ddr2_aref;
    import ddr2_aref_pkg::*;

    localparam int TREFI = 100;
    localparam int TRP   = 5;
    localparam int TRFC  = 51;
    localparam int MAXP  = 8;

    localparam logic [3:0] E_NOP  = 4'b0111;
    localparam logic [3:0] E_PRE  = 4'b0010;
    localparam logic [3:0] E_AREF = 4'b0001;

    // event kinds on the bus: 0 nothing, 1 PRE, 2 AREF, 3 end pulse, 9 illegal
    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic                 ck = 1'b0;
    logic                 rst;
    logic                 init_end;
    logic                 aref_en;
    logic                 aref_req;
    logic                 aref_busy;
    logic [3:0]           aref_cmd;
    logic [BA_BITS-1:0]   aref_ba;
    logic [ADDR_BITS-1:0] aref_addr;
    logic                 aref_end;
    logic                 aref_overflow;

    ddr2_aref #(
        .TREFI_CK(TREFI),
        .TRP_CK  (TRP),
        .TRFC_CK (TRFC),
        .MAX_PEND(MAXP)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .init_end     (init_end),
        .aref_en      (aref_en),
        .aref_req     (aref_req),
        .aref_busy    (aref_busy),
        .aref_cmd     (aref_cmd),
        .aref_ba      (aref_ba),
        .aref_addr    (aref_addr),
        .aref_end     (aref_end),
        .aref_overflow(aref_overflow)
    );

    always #5 ck = ~ck;

    int  n_cmp = 0;
    int  n_bad = 0;

    // reference model state
    int  cyc = 0;       // number of rising edges so far
    int  k = 0;         // edges with init_end high since reset / init low
    int  pend = 0;
    int  seq_end = 0;   // edge at which the running sequence returns to idle
    bit  in_seq = 0;
    bit  ovf = 0;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: refresh owed every TREFI cycles of init_end, each grant
    // schedules PRE, AREF and end pulse at fixed offsets from the grant edge.
    always @(posedge ck) begin
        bit req_pre, tick, done;
        cyc++;
        if (rst) begin
            pend   = 0;
            ovf    = 0;
            in_seq = 0;
            k      = 0;
            exp_q.delete();
        end else begin
            req_pre = !in_seq && init_end && (pend != 0);
            if (init_end) k++;
            else          k = 0;
            tick = init_end && (k % TREFI == 0);
            done = in_seq && (cyc == seq_end);
            if (tick && !done) begin
                if (pend == MAXP) ovf = 1;
                else              pend++;
            end else if (done && !tick) begin
                pend--;
            end
            if (done) in_seq = 0;
            if (req_pre && aref_en) begin
                in_seq  = 1;
                seq_end = cyc + TRP + TRFC;
                exp_q.push_back(ev_t'{cyc, 1});
                exp_q.push_back(ev_t'{cyc + TRP, 2});
                exp_q.push_back(ev_t'{cyc + TRP + TRFC - 1, 3});
            end
        end
    end

    // Monitor: compare bus activity and status flags once per cycle
    always @(negedge ck) begin
        int obs, exp_kind;
        bit exp_req;
        if (cyc > 0) begin
            exp_req = !in_seq && init_end && (pend != 0);
            chk("status{req,busy,ovf}", {29'd0, aref_req, aref_busy, aref_overflow},
                {29'd0, exp_req, in_seq, ovf});
            chk("bank_addr", 32'(aref_ba), 32'd0);
            exp_kind = 0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_kind = exp_q[0].kind;
                void'(exp_q.pop_front());
            end
            if (aref_cmd == E_PRE && !aref_end)       obs = 1;
            else if (aref_cmd == E_AREF && !aref_end) obs = 2;
            else if (aref_cmd == E_NOP && aref_end)   obs = 3;
            else if (aref_cmd == E_NOP)               obs = 0;
            else                                      obs = 9;
            chk("bus_event", 32'(obs), 32'(exp_kind));
            chk("addr", 32'(aref_addr), (exp_kind == 1) ? 32'h400 : 32'd0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        init_end = 1'b0;
        aref_en  = 1'b0;
        cycles(3);
        #3;
        chk("reset_outputs",
            {11'd0, aref_cmd, aref_addr, aref_ba, aref_req, aref_busy, aref_end, aref_overflow},
            {11'd0, E_NOP, 13'h0, 2'b00, 4'b0000});
        cycles(2);
        rst = 1'b0;

        // init not done: grants must be ignored, no refresh activity
        for (int i = 0; i < 1000; i++) begin
            aref_en = 1'($urandom_range(0, 1));
            cycles(1);
        end

        // init done, arbiter always grants
        init_end = 1'b1;
        aref_en  = 1'b1;
        cycles(400);

        // arbiter starves refresh long enough to overflow the postpone budget
        aref_en = 1'b0;
        cycles(950);
        chk("overflow_set", 32'(aref_overflow), 32'd1);
        aref_en = 1'b1;
        cycles(1400);
        chk("overflow_sticky", 32'(aref_overflow), 32'd1);

        // random grant pattern, including drops in the middle of sequences
        for (int i = 0; i < 3000; i++) begin
            aref_en = ($urandom_range(0, 3) == 0);
            cycles(1);
        end

        // line up a completion with a tick so pending must stay the same
        aref_en = 1'b0;
        rst     = 1'b1;
        cycles(2);
        rst = 1'b0;
        n = 0;
        while (k != 143 && n < 500) begin
            cycles(1);
            n++;
        end
        chk("wait_grant_slot", 32'(k), 32'd143);
        aref_en = 1'b1;
        cycles(1);
        aref_en = 1'b0;
        n = 0;
        while (k != 200 && n < 200) begin
            cycles(1);
            n++;
        end
        chk("coincident_req", 32'(aref_req), 32'd1);
        cycles(60);

        // reset in the middle of the tRFC wait
        aref_en = 1'b1;
        n = 0;
        while (!(in_seq && seq_end - cyc == 20) && n < 500) begin
            cycles(1);
            n++;
        end
        chk("wait_wrfc", 32'(in_seq && (seq_end - cyc == 20)), 32'd1);
        rst = 1'b1;
        cycles(1);
        chk("reset_abort", {26'd0, aref_cmd, aref_busy, aref_req}, {26'd0, E_NOP, 2'b00});
        rst = 1'b0;
        cycles(300);

        aref_en = 1'b0;
        cycles(100);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
